multi_cycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath. Sequences every instruction through fetch, decode, execute, memory and writeback. Produces the enable strobes for the datapath registers (PC, IR, register file, memory) and the mux/ALU selects.
- Registers are enable-gated flops. This block is the only source of their enables.
- Inserts wait states on a memory-ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 71 +++++++
 rtl/mips_ctrl_outdec.sv | 72 +++++++
 rtl/multi_cycle_ctrl.sv | 90 +++++++++
 tb/tb_multi_cycle_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, FSM states,
// datapath select encodings and the decoded control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IEXEC   = 4'd9,
        S_IWB     = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_e;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BTA  = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ir_write/pc_write here are requests; the FSM gates them with mem_ready in FETCH.
    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
    } ctrl_word_t;

    function automatic state_e decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:   return S_MEMADR;
            OP_RTYPE:       return S_EXEC;
            OP_BEQ, OP_BNE: return S_BRANCH;
            OP_ADDI:        return S_IEXEC;
            OP_J:           return S_JUMP;
            default:        return S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Purely combinational decode of the current FSM state into the Moore part
// of the datapath control word.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_e     state_i,
    output ctrl_word_t ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_BTA;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.pc_src    = PCSRC_ALUOUT;
                ctrl_o.branch    = 1'b1;
            end
            S_IEXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_IWB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_src   = PCSRC_JUMP;
                ctrl_o.pc_write = 1'b1;
            end
            S_ILLEGAL: begin
                ctrl_o.illegal_op = 1'b1;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: state register, next-state
// sequencing with memory wait states, and gating of the register enables.
module multi_cycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OP_WIDTH    = 6,
    parameter int STATE_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_en,
    output logic                ir_write,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_src,
    output logic                illegal_op
);

    logic [STATE_WIDTH-1:0] state_q;
    logic [STATE_WIDTH-1:0] state_d;
    ctrl_word_t             cw;
    logic                   mem_gate;
    logic                   pc_write;
    logic                   take_branch;

    mips_ctrl_outdec u_outdec (
        .state_i (state_e'(state_q)),
        .ctrl_o  (cw)
    );

    // Unused encodings fall into the default arm and recover to FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE:  state_d = decode_next(opcode);
            S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC:    state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_IEXEC:   state_d = S_IWB;
            S_IWB:     state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_ILLEGAL: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch only commits PC/IR in the cycle memory actually returns the word.
    assign mem_gate    = (state_q == S_FETCH) ? mem_ready : 1'b1;
    assign pc_write    = cw.pc_write & mem_gate;
    assign take_branch = cw.branch & (zero ^ (opcode == OP_BNE));

    assign pc_en      = ~reset & (pc_write | take_branch);
    assign ir_write   = ~reset & cw.ir_write & mem_gate;
    assign reg_write  = ~reset & cw.reg_write;
    assign mem_write  = ~reset & cw.mem_write;
    assign illegal_op = ~reset & cw.illegal_op;

    assign iord       = cw.iord;
    assign mem_read   = cw.mem_read;
    assign reg_dst    = cw.reg_dst;
    assign mem_to_reg = cw.mem_to_reg;
    assign alu_src_a  = cw.alu_src_a;
    assign alu_src_b  = cw.alu_src_b;
    assign alu_op     = cw.alu_op;
    assign pc_src     = cw.pc_src;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: latency table, hand-written reset/wait corner
// cases and random instruction streams against a step-list reference model.
module tb_multi_cycle_ctrl;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_BNE   = 6'b000101;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_J     = 6'b000010;

    typedef enum int {
        ST_FETCH, ST_DECODE, ST_ADDR, ST_RD, ST_RDWB, ST_WR, ST_EX, ST_EXWB,
        ST_BRANCH, ST_IEX, ST_IWB, ST_JUMP, ST_ILL
    } step_e;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
    } out_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        int         z;
        int         cyc;
        int         pcen;
        int         regw;
        int         memw;
        int         ill;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, ir_write, iord, mem_read, mem_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    step_e prog[8];
    int    prog_n;
    int    n_cyc, n_pcen, n_regw, n_memw, n_ill, n_iord_memw;
    out_t  rst_exp;
    vec_t  tbl[11];

    multi_cycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .ir_write   (ir_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal_op (illegal_op)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic out_t ref_out(input step_e s, input logic mr, input logic z,
                                     input logic [5:0] op);
        out_t o;
        o = '0;
        case (s)
            ST_FETCH:  begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_en = mr; end
            ST_DECODE: o.alu_src_b = 2'b11;
            ST_ADDR:   begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            ST_RD:     begin o.iord = 1'b1; o.mem_read = 1'b1; end
            ST_RDWB:   begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
            ST_WR:     begin o.iord = 1'b1; o.mem_write = 1'b1; end
            ST_EX:     begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
            ST_EXWB:   begin o.reg_dst = 1'b1; o.reg_write = 1'b1; end
            ST_BRANCH: begin
                o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_src = 2'b01;
                o.pc_en = z ^ (op == T_BNE);
            end
            ST_IEX:    begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            ST_IWB:    o.reg_write = 1'b1;
            ST_JUMP:   begin o.pc_src = 2'b10; o.pc_en = 1'b1; end
            ST_ILL:    o.illegal_op = 1'b1;
            default:   o = '0;
        endcase
        return o;
    endfunction

    function automatic logic is_mem_step(input step_e s);
        return (s == ST_FETCH) || (s == ST_RD) || (s == ST_WR);
    endfunction

    task automatic load_prog(input logic [5:0] op);
        prog[0] = ST_FETCH;
        prog[1] = ST_DECODE;
        case (op)
            T_LW:          begin prog[2] = ST_ADDR; prog[3] = ST_RD; prog[4] = ST_RDWB; prog_n = 5; end
            T_SW:          begin prog[2] = ST_ADDR; prog[3] = ST_WR; prog_n = 4; end
            T_RTYPE:       begin prog[2] = ST_EX;   prog[3] = ST_EXWB; prog_n = 4; end
            T_ADDI:        begin prog[2] = ST_IEX;  prog[3] = ST_IWB;  prog_n = 4; end
            T_BEQ, T_BNE:  begin prog[2] = ST_BRANCH; prog_n = 3; end
            T_J:           begin prog[2] = ST_JUMP; prog_n = 3; end
            default:       begin prog[2] = ST_ILL;  prog_n = 3; end
        endcase
    endtask

    // ---------------- driver / checker tasks ----------------
    function automatic out_t cur_out();
        out_t o;
        o = {pc_en, ir_write, iord, mem_read, mem_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};
        return o;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic mr, input logic z, input logic [5:0] op);
        @(posedge clk);
        #1;
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        @(negedge clk);
    endtask

    task automatic step_chk(input step_e s, input logic mr, input logic z,
                            input logic [5:0] op, input string name);
        apply(mr, z, op);
        check(name, cur_out(), ref_out(s, mr, z, op));
    endtask

    // wmode: 0 = memory always ready, 1 = random waits, 2 = three waits on the data access
    task automatic run_instr(input logic [5:0] op, input int zmode, input int wmode,
                             input string tag);
        int   idx = 0;
        int   wait_left = 3;
        logic mr, z;
        out_t exp, act;
        load_prog(op);
        n_cyc = 0; n_pcen = 0; n_regw = 0; n_memw = 0; n_ill = 0; n_iord_memw = 0;
        while (idx < prog_n) begin
            if (n_cyc >= 64) begin
                checks++;
                errors++;
                $display("FAIL %s timeout got %0d cycles exp at most 64", tag, n_cyc);
                return;
            end
            case (wmode)
                0: mr = 1'b1;
                1: mr = ($urandom_range(0, 3) != 0);
                default: begin
                    if ((prog[idx] == ST_RD || prog[idx] == ST_WR) && wait_left > 0) begin
                        mr = 1'b0;
                        wait_left--;
                    end else begin
                        mr = 1'b1;
                    end
                end
            endcase
            z = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            apply(mr, z, op);
            exp = ref_out(prog[idx], mr, z, op);
            exp_q.push_back(exp);
            act = cur_out();
            check(tag, act, exp_q.pop_front());
            n_pcen      += int'(act.pc_en);
            n_regw      += int'(act.reg_write);
            n_memw      += int'(act.mem_write);
            n_ill       += int'(act.illegal_op);
            n_iord_memw += int'(act.iord & act.mem_write);
            if (!(is_mem_step(prog[idx]) && !mr)) idx++;
            n_cyc++;
        end
    endtask

    // Idle FETCH cycle (memory not ready) that confirms the instruction has retired.
    task automatic probe_fetch(input string name);
        apply(1'b0, 1'b0, T_RTYPE);
        check(name, cur_out(), ref_out(ST_FETCH, 1'b0, 1'b0, T_RTYPE));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        tbl[0]  = '{"lw",       T_LW,    0, 5, 1, 1, 0, 0};
        tbl[1]  = '{"sw",       T_SW,    0, 4, 1, 0, 1, 0};
        tbl[2]  = '{"rtype",    T_RTYPE, 0, 4, 1, 1, 0, 0};
        tbl[3]  = '{"addi",     T_ADDI,  0, 4, 1, 1, 0, 0};
        tbl[4]  = '{"beq_z1",   T_BEQ,   1, 3, 2, 0, 0, 0};
        tbl[5]  = '{"beq_z0",   T_BEQ,   0, 3, 1, 0, 0, 0};
        tbl[6]  = '{"bne_z1",   T_BNE,   1, 3, 1, 0, 0, 0};
        tbl[7]  = '{"bne_z0",   T_BNE,   0, 3, 2, 0, 0, 0};
        tbl[8]  = '{"j",        T_J,     0, 3, 2, 0, 0, 0};
        tbl[9]  = '{"ill_3f",   6'h3f,   0, 3, 1, 0, 0, 1};
        tbl[10] = '{"ill_20",   6'h20,   0, 3, 1, 0, 0, 1};

        rst_exp = '0;
        rst_exp.mem_read  = 1'b1;
        rst_exp.alu_src_b = 2'b01;

        // reset with memory ready: fetch enables must stay forced low
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = T_LW;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_forced", cur_out(), rst_exp);
        @(posedge clk);
        #1;
        reset = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("reset_release_fetch", cur_out(), ref_out(ST_FETCH, 1'b0, 1'b0, T_LW));

        // latency / enable-count table, memory always ready
        for (int i = 0; i < 11; i++) begin
            run_instr(tbl[i].op, tbl[i].z, 0, tbl[i].name);
            check_int({tbl[i].name, "_cycles"}, n_cyc, tbl[i].cyc);
            check_int({tbl[i].name, "_pc_en"},  n_pcen, tbl[i].pcen);
            check_int({tbl[i].name, "_reg_wr"}, n_regw, tbl[i].regw);
            check_int({tbl[i].name, "_mem_wr"}, n_memw, tbl[i].memw);
            check_int({tbl[i].name, "_illegal"}, n_ill, tbl[i].ill);
            probe_fetch({tbl[i].name, "_retire"});
        end

        // SW stalled three cycles in the write
        run_instr(T_SW, 0, 2, "sw_wait");
        check_int("sw_wait_cycles", n_cyc, 7);
        check_int("sw_wait_mem_wr", n_memw, 4);
        check_int("sw_wait_iord_wr", n_iord_memw, 4);
        check_int("sw_wait_reg_wr", n_regw, 0);
        probe_fetch("sw_wait_retire");

        // LW stalled three cycles in the read
        run_instr(T_LW, 1, 2, "lw_wait");
        check_int("lw_wait_cycles", n_cyc, 8);
        check_int("lw_wait_reg_wr", n_regw, 1);
        probe_fetch("lw_wait_retire");

        // reset asserted while LW waits in the memory read
        step_chk(ST_FETCH,  1'b1, 1'b0, T_LW, "rmid_fetch");
        step_chk(ST_DECODE, 1'b1, 1'b0, T_LW, "rmid_decode");
        step_chk(ST_ADDR,   1'b1, 1'b0, T_LW, "rmid_addr");
        step_chk(ST_RD,     1'b0, 1'b0, T_LW, "rmid_rd0");
        step_chk(ST_RD,     1'b0, 1'b0, T_LW, "rmid_rd1");
        #2;
        reset = 1'b1;
        #1;
        check("rmid_forced", cur_out(), rst_exp);
        @(posedge clk);
        #1;
        reset = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("rmid_release", cur_out(), ref_out(ST_FETCH, 1'b0, 1'b0, T_LW));
        step_chk(ST_FETCH,  1'b1, 1'b0, T_LW, "rmid_refetch");
        step_chk(ST_DECODE, 1'b1, 1'b0, T_LW, "rmid_redecode");
        step_chk(ST_ADDR,   1'b1, 1'b0, T_LW, "rmid_readdr");
        step_chk(ST_RD,     1'b1, 1'b0, T_LW, "rmid_rerd");
        step_chk(ST_RDWB,   1'b1, 1'b0, T_LW, "rmid_rewb");

        // random instruction stream with random waits and zero flag
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op;
            case ($urandom_range(0, 9))
                0: op = T_RTYPE;
                1: op = T_LW;
                2: op = T_SW;
                3: op = T_BEQ;
                4: op = T_BNE;
                5: op = T_ADDI;
                6: op = T_J;
                default: op = 6'($urandom_range(0, 63));
            endcase
            run_instr(op, -1, 1, "rand");
        end
        probe_fetch("rand_retire");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
